fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_fifo.sv | 54 +++++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions used by the fetch stage: reset PC, ECALL encoding
// and the fetch run/halt state.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0100_0000;
    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Instruction buffer for the fetch stage: DEPTH entries of {pc, insn} with flush.
// The head entry is read straight out of the storage registers.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only taken when the head leaves in the same cycle
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response tracking
// with discard after redirect/ecall, and a small buffer feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(RESET_PC),
    parameter int                DEPTH     = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [AWIDTH-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [AWIDTH-1:0] insn_pc,
    output logic [DWIDTH-1:0] insn_data,
    output logic              halted
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

    logic [AWIDTH-1:0]        fetch_pc;
    logic [AWIDTH-1:0]        rsp_pc;
    logic [CW-1:0]            in_flight;
    logic [CW-1:0]            drop_cnt;
    logic [CW-1:0]            fifo_count;
    fetch_state_t             state;

    logic [AWIDTH+DWIDTH-1:0] head;
    logic [CW:0]              credits_used;
    logic [CW-1:0]            in_flight_nxt;
    logic [AWIDTH-1:0]        target_pc;
    logic                     req_fire;
    logic                     pop;
    logic                     push;
    logic                     flush;
    logic                     is_ecall;
    logic                     rsp_drop;

    // Outstanding requests plus buffered instructions may never exceed the buffer size
    assign credits_used   = {1'b0, in_flight} + {1'b0, fifo_count};
    assign imem_req_valid = reset && (state == ST_RUN) && !redirect_valid
                            && (credits_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign insn_valid = (fifo_count != '0) && (state == ST_RUN);
    assign insn_pc    = insn_valid ? head[AWIDTH+DWIDTH-1:DWIDTH] : '0;
    assign insn_data  = insn_valid ? head[DWIDTH-1:0] : '0;
    assign halted     = (state == ST_HALT);

    assign pop      = insn_valid && insn_ready && !redirect_valid;
    assign is_ecall = pop && (insn_data == DWIDTH'(ECALL_INSN));
    assign rsp_drop = (drop_cnt != '0);
    assign push     = imem_rsp_valid && !rsp_drop && (state == ST_RUN) && !redirect_valid;
    assign flush    = redirect_valid || is_ecall;

    assign in_flight_nxt = in_flight + CW'(req_fire) - CW'(imem_rsp_valid);
    assign target_pc     = redirect_pc & ~AWIDTH'(3);

    // Responses already requested when a redirect or ecall hits are counted into
    // drop_cnt, so they are discarded as they return in order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= BASE_ADDR;
            rsp_pc    <= BASE_ADDR;
            in_flight <= '0;
            drop_cnt  <= '0;
            state     <= ST_RUN;
        end else if (redirect_valid) begin
            fetch_pc  <= target_pc;
            rsp_pc    <= target_pc;
            in_flight <= in_flight_nxt;
            drop_cnt  <= in_flight_nxt;
            state     <= ST_RUN;
        end else begin
            in_flight <= in_flight_nxt;
            if (req_fire) fetch_pc <= fetch_pc + AWIDTH'(4);
            if (push)     rsp_pc   <= rsp_pc + AWIDTH'(4);
            if (is_ecall) begin
                state    <= ST_HALT;
                drop_cnt <= in_flight_nxt;
            end else if (imem_rsp_valid && rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AWIDTH + DWIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle in-order instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn_pc;
    logic [31:0] insn_data;
    logic        halted;

    int passes = 0;
    int checks = 0;
    int cyc = 0;
    int max_pend = 0;
    logic        mem_en = 1'b1;
    logic [31:0] ecall_addr = 32'hFFFF_FFFF;
    logic [31:0] last_pc;

    logic [31:0] pending[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];
    int          pop_cyc[$];

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn_pc        (insn_pc),
        .insn_data      (insn_data),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn_at(input logic [31:0] a);
        if (a == ecall_addr) return ECALL;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    task automatic clear_logs();
        req_log.delete(); req_cyc.delete();
        pop_pc.delete(); pop_data.delete(); pop_cyc.delete();
    endtask

    // One clock: sample handshakes mid-cycle, then schedule the next memory response.
    task automatic cycle();
        logic [31:0] a;
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pending.push_back(imem_req_addr);
            req_log.push_back(imem_req_addr);
            req_cyc.push_back(cyc);
        end
        if (insn_valid && insn_ready && !redirect_valid) begin
            pop_pc.push_back(insn_pc);
            pop_data.push_back(insn_data);
            pop_cyc.push_back(cyc);
        end
        if (pending.size() > max_pend) max_pend = pending.size();
        @(posedge clk); #1;
        cyc++;
        if (mem_en && pending.size() > 0) begin
            a = pending.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = insn_at(a);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; insn_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %0b want 0", imem_req_valid); else passes++;
        checks++; if (insn_valid !== 1'b0) $display("FAIL rst_insn_valid: got %0b want 0", insn_valid); else passes++;
        checks++; if (insn_pc !== 32'h0) $display("FAIL rst_insn_pc: got %h want 0", insn_pc); else passes++;
        checks++; if (insn_data !== 32'h0) $display("FAIL rst_insn_data: got %h want 0", insn_data); else passes++;
        checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %0b want 0", halted); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %0b want 1", imem_req_valid); else passes++;
        checks++; if (imem_req_addr !== 32'h0100_0000) $display("FAIL first_req_addr: got %h want 01000000", imem_req_addr); else passes++;
    endtask

    task automatic test_basic();
        clear_logs();
        repeat (10) cycle();
        checks++; if (req_log[0] !== 32'h0100_0000) $display("FAIL basic_req0: got %h want 01000000", req_log[0]); else passes++;
        checks++; if (req_log[1] !== 32'h0100_0004) $display("FAIL basic_req1: got %h want 01000004", req_log[1]); else passes++;
        checks++; if (req_log[2] !== 32'h0100_0008) $display("FAIL basic_req2: got %h want 01000008", req_log[2]); else passes++;
        checks++; if (req_cyc[1] !== req_cyc[0] + 1) $display("FAIL basic_req_b2b: got cycle %0d want %0d", req_cyc[1], req_cyc[0] + 1); else passes++;
        checks++; if (pop_cyc[0] !== req_cyc[0] + 2) $display("FAIL basic_latency: got cycle %0d want %0d", pop_cyc[0], req_cyc[0] + 2); else passes++;
        checks++; if (pop_pc[0] !== 32'h0100_0000) $display("FAIL basic_pc0: got %h want 01000000", pop_pc[0]); else passes++;
        checks++; if (pop_pc[1] !== 32'h0100_0004) $display("FAIL basic_pc1: got %h want 01000004", pop_pc[1]); else passes++;
        checks++; if (pop_pc[2] !== 32'h0100_0008) $display("FAIL basic_pc2: got %h want 01000008", pop_pc[2]); else passes++;
        checks++; if (pop_data[0] !== insn_at(32'h0100_0000)) $display("FAIL basic_data0: got %h want %h", pop_data[0], insn_at(32'h0100_0000)); else passes++;
        last_pc = pop_pc[pop_pc.size()-1];
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        clear_logs();
        max_pend = 0;
        insn_ready = 1'b0;
        repeat (10) cycle();
        checks++; if (req_log.size() > 2) $display("FAIL stall_reqs: got %0d want <=2", req_log.size()); else passes++;
        checks++; if (max_pend > 2) $display("FAIL stall_outstanding: got %0d want <=2", max_pend); else passes++;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL stall_full_req: got %0b want 0", imem_req_valid); else passes++;
        checks++; if (insn_valid !== 1'b1) $display("FAIL stall_valid: got %0b want 1", insn_valid); else passes++;
        insn_ready = 1'b1;
        repeat (12) cycle();
        checks++; if (pop_pc.size() < 6) $display("FAIL stall_drain_count: got %0d want >=6", pop_pc.size()); else passes++;
        exp = last_pc + 32'd4;
        foreach (pop_pc[i]) begin
            checks++; if (pop_pc[i] !== exp) $display("FAIL stall_seq_pc: got %h want %h", pop_pc[i], exp); else passes++;
            checks++; if (pop_data[i] !== insn_at(exp)) $display("FAIL stall_seq_data: got %h want %h", pop_data[i], insn_at(exp)); else passes++;
            exp = exp + 32'd4;
        end
    endtask

    task automatic test_redirect();
        int n = 0;
        clear_logs();
        insn_ready = 1'b1;
        mem_en = 1'b0;
        while (!(pending.size() == 2 && !imem_rsp_valid && !insn_valid) && n < 20) begin
            cycle(); n++;
        end
        checks++; if (pending.size() != 2) $display("FAIL redir_setup: got %0d in flight want 2", pending.size()); else passes++;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0043;
        #1;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL redir_no_req: got %0b want 0", imem_req_valid); else passes++;
        clear_logs();
        cycle();
        redirect_valid = 1'b0;
        mem_en = 1'b1;
        repeat (12) cycle();
        checks++; if (req_log[0] !== 32'h0100_0040) $display("FAIL redir_req: got %h want 01000040", req_log[0]); else passes++;
        checks++; if (pop_pc[0] !== 32'h0100_0040) $display("FAIL redir_pc0: got %h want 01000040", pop_pc[0]); else passes++;
        checks++; if (pop_data[0] !== insn_at(32'h0100_0040)) $display("FAIL redir_data0: got %h want %h", pop_data[0], insn_at(32'h0100_0040)); else passes++;
        checks++; if (pop_pc[1] !== 32'h0100_0044) $display("FAIL redir_pc1: got %h want 01000044", pop_pc[1]); else passes++;
    endtask

    task automatic test_ecall();
        int  n = 0;
        bit  found = 0;
        ecall_addr = 32'h0100_000C;
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0000;
        cycle();
        redirect_valid = 1'b0;
        clear_logs();
        while (!found && n < 40) begin
            cycle(); n++;
            if (pop_pc.size() > 0 && pop_pc[pop_pc.size()-1] == 32'h0100_000C) found = 1;
        end
        checks++; if (!found) $display("FAIL ecall_seen: got none want pop at 0100000c"); else passes++;
        checks++; if (pop_data[pop_data.size()-1] !== ECALL) $display("FAIL ecall_data: got %h want %h", pop_data[pop_data.size()-1], ECALL); else passes++;
        checks++; if (halted !== 1'b1) $display("FAIL ecall_halted: got %0b want 1", halted); else passes++;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL ecall_no_req: got %0b want 0", imem_req_valid); else passes++;
        checks++; if (insn_valid !== 1'b0) $display("FAIL ecall_no_insn: got %0b want 0", insn_valid); else passes++;
        clear_logs();
        repeat (6) cycle();
        checks++; if (req_log.size() != 0) $display("FAIL halt_reqs: got %0d want 0", req_log.size()); else passes++;
        checks++; if (pop_pc.size() != 0) $display("FAIL halt_pops: got %0d want 0", pop_pc.size()); else passes++;
        checks++; if (halted !== 1'b1) $display("FAIL halt_hold: got %0b want 1", halted); else passes++;
        // The resumed stream starts with an ecall so the next test can collide it with a redirect
        ecall_addr = 32'h0100_0100;
        insn_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0100;
        cycle();
        redirect_valid = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) $display("FAIL resume_halted: got %0b want 0", halted); else passes++;
        checks++; if (imem_req_valid !== 1'b1) $display("FAIL resume_req_valid: got %0b want 1", imem_req_valid); else passes++;
        checks++; if (imem_req_addr !== 32'h0100_0100) $display("FAIL resume_req_addr: got %h want 01000100", imem_req_addr); else passes++;
    endtask

    task automatic test_redirect_ecall();
        int n = 0;
        while (!insn_valid && n < 20) begin
            cycle(); n++;
        end
        checks++; if (insn_pc !== 32'h0100_0100) $display("FAIL rx_head_pc: got %h want 01000100", insn_pc); else passes++;
        checks++; if (insn_data !== ECALL) $display("FAIL rx_head_data: got %h want %h", insn_data, ECALL); else passes++;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0200;
        insn_ready = 1'b1;
        clear_logs();
        cycle();
        redirect_valid = 1'b0;
        ecall_addr = 32'hFFFF_FFFF;
        #1;
        checks++; if (halted !== 1'b0) $display("FAIL rx_halted: got %0b want 0", halted); else passes++;
        checks++; if (insn_valid !== 1'b0) $display("FAIL rx_flushed: got %0b want 0", insn_valid); else passes++;
        repeat (10) cycle();
        checks++; if (halted !== 1'b0) $display("FAIL rx_still_run: got %0b want 0", halted); else passes++;
        checks++; if (req_log[0] !== 32'h0100_0200) $display("FAIL rx_req: got %h want 01000200", req_log[0]); else passes++;
        checks++; if (pop_pc[0] !== 32'h0100_0200) $display("FAIL rx_pc0: got %h want 01000200", pop_pc[0]); else passes++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        insn_ready = 1'b0;
        while (!(insn_valid && !imem_req_valid && pending.size() == 0 && !imem_rsp_valid) && n < 20) begin
            cycle(); n++;
        end
        checks++; if (!(insn_valid && !imem_req_valid)) $display("FAIL rm_full: got valid=%0b req=%0b want 1/0", insn_valid, imem_req_valid); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL rm_req_valid: got %0b want 0", imem_req_valid); else passes++;
        checks++; if (insn_valid !== 1'b0) $display("FAIL rm_insn_valid: got %0b want 0", insn_valid); else passes++;
        checks++; if (insn_pc !== 32'h0) $display("FAIL rm_insn_pc: got %h want 0", insn_pc); else passes++;
        checks++; if (insn_data !== 32'h0) $display("FAIL rm_insn_data: got %h want 0", insn_data); else passes++;
        checks++; if (halted !== 1'b0) $display("FAIL rm_halted: got %0b want 0", halted); else passes++;
        pending.delete();
        imem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) $display("FAIL rm_first_valid: got %0b want 1", imem_req_valid); else passes++;
        checks++; if (imem_req_addr !== 32'h0100_0000) $display("FAIL rm_first_addr: got %h want 01000000", imem_req_addr); else passes++;
        insn_ready = 1'b1;
        clear_logs();
        repeat (8) cycle();
        checks++; if (pop_pc[0] !== 32'h0100_0000) $display("FAIL rm_pc0: got %h want 01000000", pop_pc[0]); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_ecall();
        test_redirect_ecall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
